ushift_reg: RTL and testbench
=============================

# ushift_reg

Parametrised universal shift register: WIDTH-bit register with hold, shift-left, shift-right and parallel-load modes, serial inputs and outputs at both ends, and a shift counter that flags each completed word. Successor to the fixed 4-bit serial-in/parallel-out register. Used as the general serialiser/deserialiser in the datapath, for example as SIPO on receive and PISO on transmit.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- en  in  1  shift/load enable; 0 forces hold.
- mode  in  2  0=HOLD, 1=SHL (toward MSB), 2=SHR (toward LSB), 3=LOAD.
- sin_lsb  in  1  serial input entering bit 0 on SHL.
- sin_msb  in  1  serial input entering bit WIDTH-1 on SHR.
- pin  in  WIDTH  parallel load data.
- rot  in  1  rotate select; present only with USHIFT_ROTATE_EN.
- out  out  WIDTH  register contents.
- sout_msb  out  1  equals out[WIDTH-1].
- sout_lsb  out  1  equals out[0].
- cnt  out  $clog2(WIDTH+1)  shifts since last LOAD, word boundary or reset.
- word_done  out  1  one-cycle pulse after the WIDTH-th shift.

## Operation
- Effective mode is HOLD when en=0, otherwise mode.
- HOLD: out, cnt unchanged; word_done=0.
- SHL: out <= {out[WIDTH-2:0], sin_lsb}.
- SHR: out <= {sin_msb, out[WIDTH-1:1]}.
- LOAD: out <= pin; cnt <= 0; word_done <= 0.
- Shift counter:
  - Increments on every SHL or SHR, regardless of direction.
  - A shift with cnt==WIDTH-1 sets cnt <= 0 and word_done <= 1.
  - Every other cycle sets word_done <= 0.
- Direction change mid-word: cnt continues and is not cleared.
- Reset values: out=0, cnt=0, word_done=0, sout_msb=0, sout_lsb=0.
- Reset mid-word: all state clears asynchronously. The first posedge after release behaves as from power-up.

## Timing
- All outputs are registered or direct taps of registers. There is no combinational path from inputs to outputs.
- Serial-to-parallel latency: sin_lsb sampled at edge k appears on out[0] after edge k. It reaches sout_msb after edge k+WIDTH-1.
- LOAD-to-serial latency: a word loaded at edge k has pin[WIDTH-1] on sout_msb right after edge k. After WIDTH SHL edges all bits have been presented.
- word_done is high for exactly the cycle following the WIDTH-th shift edge. Back-to-back words give a pulse every WIDTH enabled shifts.
- en may toggle on any cycle. Disabled cycles do not count.
- Reset release must meet recovery/removal timing to clk. No synchroniser is included.

## Configuration
- Macro: USHIFT_ROTATE_EN.
- Defined:
  - The rot port exists.
  - With rot=1, SHL feeds out[WIDTH-1] into bit 0 and SHR feeds out[0] into bit WIDTH-1; the sin_* inputs are ignored.
  - Counter and word_done behave identically to ordinary shifts.
- Undefined:
  - The rot port is absent.
  - Shifts always take sin_lsb/sin_msb.

## Structure
- Package ushift_pkg holds:
  - typedef enum logic [1:0] ushift_mode_t {HOLD, SHL, SHR, LOAD}.
  - A function for counter width, $clog2(WIDTH+1).
- Sub-module ushift_cell: one bit of the register.
  - 4:1 next-state mux (hold / left neighbour / right neighbour / pin bit) plus a flop with asynchronous active-low clear.
  - Instantiated WIDTH times by generate; the end cells take the serial or rotate inputs.
- The counter and word_done logic live in ushift_reg.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive reset=0 asynchronously mid-cycle with out=8'hA5 -> out=0, cnt=0, word_done=0 before the next edge.
- LOAD pin=8'hC3, then 8 SHL with sin_lsb=0 -> sout_msb sequence 1,1,0,0,0,0,1,1; out=8'h00; word_done pulses once after the 8th shift.
- SIPO: after reset, SHR with sin_msb stream 1,0,1,1,0,0,1,0 -> out=8'h4D; cnt wraps to 0 with a single word_done pulse.
- en toggling: 8 SHL interleaved with en=0 cycles -> cnt holds on disabled cycles; word_done appears only after the 8th enabled shift.
- Mid-word: 3 SHL then LOAD 8'hFF -> cnt=0 and no word_done. Mid-word 5 SHL then reset -> all outputs 0.
- USHIFT_ROTATE_EN: LOAD 8'h81, rot=1, 1 SHL -> out=8'h03; 8 SHR from 8'h81 -> out=8'h81 with word_done pulse.

Source files
------------

// File: rtl/ushift_pkg.sv
// ============================================================================
// Module   : ushift_pkg
// Brief    : Shared mode encoding and counter-width helper for ushift_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ushift_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SHL  = 2'd1,
        SHR  = 2'd2,
        LOAD = 2'd3
    } ushift_mode_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ushift_cell.sv
// ============================================================================
// Module   : ushift_cell
// Brief    : One bit of the universal shift register: 4:1 next-state mux
//            feeding a flop with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ushift_cell
    import ushift_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  ushift_mode_t sel,
    input  logic         d_lo,
    input  logic         d_hi,
    input  logic         d_pin,
    output logic         q
);

    logic w_d;
    logic r_q;

    // d_lo is the lower-index neighbour (source on SHL), d_hi the upper one
    always_comb begin
        w_d = r_q;
        case (sel)
            HOLD: w_d = r_q;
            SHL:  w_d = d_lo;
            SHR:  w_d = d_hi;
            LOAD: w_d = d_pin;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/ushift_reg.sv
// ============================================================================
// Module   : ushift_reg
// Brief    : Parametrised universal shift register (hold/SHL/SHR/load) with
//            serial taps at both ends and a per-word shift counter.
//            Optional rotate mode enabled by macro USHIFT_ROTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ushift_reg
    import ushift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic                        sin_lsb,
    input  logic                        sin_msb,
    input  logic [WIDTH-1:0]            pin,
`ifdef USHIFT_ROTATE_EN
    input  logic                        rot,
`endif
    output logic [WIDTH-1:0]            out,
    output logic                        sout_msb,
    output logic                        sout_lsb,
    output logic [cnt_width(WIDTH)-1:0] cnt,
    output logic                        word_done
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    ushift_mode_t       w_mode;
    logic               w_shift;
    logic               w_fill_lsb;
    logic               w_fill_msb;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH+1:0]   w_ext;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_word_done;

    assign w_mode  = en ? ushift_mode_t'(mode) : HOLD;
    assign w_shift = (w_mode == SHL) || (w_mode == SHR);

`ifdef USHIFT_ROTATE_EN
    assign w_fill_lsb = rot ? w_q[WIDTH-1] : sin_lsb;
    assign w_fill_msb = rot ? w_q[0]       : sin_msb;
`else
    assign w_fill_lsb = sin_lsb;
    assign w_fill_msb = sin_msb;
`endif

    // Padding the register with its end inputs lets every cell see
    // neighbours at w_ext[i] (below) and w_ext[i+2] (above) uniformly.
    assign w_ext = {w_fill_msb, w_q, w_fill_lsb};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ushift_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .sel   (w_mode),
            .d_lo  (w_ext[i]),
            .d_hi  (w_ext[i+2]),
            .d_pin (pin[i]),
            .q     (w_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (w_mode == LOAD) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                if (r_cnt == c_last) begin
                    r_cnt       <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out       = w_q;
    assign sout_msb  = w_q[WIDTH-1];
    assign sout_lsb  = w_q[0];
    assign cnt       = r_cnt;
    assign word_done = r_word_done;

endmodule

`default_nettype wire

// File: tb/tb_ushift_reg.sv
// ============================================================================
// Module   : tb_ushift_reg
// Brief    : Self-checking bench for ushift_reg (WIDTH=8) against a
//            behavioural model; covers rotate when USHIFT_ROTATE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ushift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic          sin_lsb;
    logic          sin_msb;
    logic [W-1:0]  pin;
    logic          rot;
    logic [W-1:0]  out;
    logic          sout_msb;
    logic          sout_lsb;
    logic [CW-1:0] cnt;
    logic          word_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_out    = '0;
    int           m_shifts = 0;
    logic         m_wd     = 1'b0;

    always #5 clk = ~clk;

    ushift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .sin_lsb   (sin_lsb),
        .sin_msb   (sin_msb),
        .pin       (pin),
`ifdef USHIFT_ROTATE_EN
        .rot       (rot),
`endif
        .out       (out),
        .sout_msb  (sout_msb),
        .sout_lsb  (sout_lsb),
        .cnt       (cnt),
        .word_done (word_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},  64'(out),       64'(m_out));
        check({tag, ".cnt"},  64'(cnt),       64'(m_shifts));
        check({tag, ".wd"},   64'(word_done), 64'(m_wd));
        check({tag, ".smsb"}, 64'(sout_msb),  64'(m_out[W-1]));
        check({tag, ".slsb"}, 64'(sout_lsb),  64'(m_out[0]));
    endtask

    // Reference: a word is WIDTH shifts; the counter is the shift count modulo WIDTH.
    task automatic model(input logic e, input logic [1:0] m, input logic sl, input logic sm,
                         input logic [W-1:0] p, input logic r);
        logic er;
        logic fill;
        logic shifted;
`ifdef USHIFT_ROTATE_EN
        er = r;
`else
        er = 1'b0 & r;
`endif
        shifted = 1'b0;
        m_wd    = 1'b0;
        if (e) begin
            case (m)
                2'd1: begin
                    fill     = er ? m_out[W-1] : sl;
                    m_out    = (m_out << 1) | {{(W-1){1'b0}}, fill};
                    shifted  = 1'b1;
                end
                2'd2: begin
                    fill     = er ? m_out[0] : sm;
                    m_out    = (m_out >> 1) | ({{(W-1){1'b0}}, fill} << (W - 1));
                    shifted  = 1'b1;
                end
                2'd3: begin
                    m_out    = p;
                    m_shifts = 0;
                end
                default: ;
            endcase
        end
        if (shifted) begin
            m_shifts = (m_shifts + 1) % W;
            m_wd     = (m_shifts == 0);
        end
    endtask

    task automatic step(input string tag, input logic e, input logic [1:0] m, input logic sl,
                        input logic sm, input logic [W-1:0] p, input logic r);
        @(negedge clk);
        en = e; mode = m; sin_lsb = sl; sin_msb = sm; pin = p; rot = r;
        @(posedge clk);
        model(e, m, sl, sm, p, r);
        #1;
        check_all(tag);
    endtask

    // Asserts reset mid-cycle and checks that it took effect before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        en    = 1'b0;
        #1;
        m_out = '0; m_shifts = 0; m_wd = 1'b0;
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] seq;
        reset = 1'b0; en = 1'b0; mode = 2'd0; sin_lsb = 1'b0; sin_msb = 1'b0;
        pin = '0; rot = 1'b0;
        repeat (2) @(negedge clk);
        check_all("rst_init");
        reset = 1'b1;

        // async reset with out=A5
        step("ldA5", 1, 2'd3, 0, 0, 8'hA5, 0);
        check("ldA5_val", 64'(out), 64'hA5);
        async_reset("rst_async");

        // PISO: C3 out of the MSB end
        seq = 8'hC3;
        step("ldC3", 1, 2'd3, 0, 0, 8'hC3, 0);
        for (int k = 0; k < 8; k++) begin
            check("piso_sout", 64'(sout_msb), 64'(seq[7-k]));
            step("piso", 1, 2'd1, 0, 0, 8'h00, 0);
        end
        check("piso_out", 64'(out), 64'h00);
        check("piso_wd", 64'(word_done), 64'h1);

        // SIPO via SHR from reset
        async_reset("rst_sipo");
        seq = 8'b1011_0010;
        for (int k = 0; k < 8; k++) step("sipo", 1, 2'd2, 0, seq[7-k], 8'h00, 0);
        check("sipo_out", 64'(out), 64'h4D);
        check("sipo_wd", 64'(word_done), 64'h1);
        check("sipo_cnt", 64'(cnt), 64'h0);

        // en toggling: disabled cycles neither shift nor count
        step("entog_ld", 1, 2'd3, 0, 0, 8'h5A, 0);
        for (int k = 0; k < 8; k++) begin
            step("entog_off", 0, 2'd1, 1, 0, 8'h00, 0);
            check("entog_cnt_hold", 64'(cnt), 64'(k));
            step("entog_on", 1, 2'd1, 1'($urandom_range(0, 1)), 0, 8'h00, 0);
            check("entog_wd", 64'(word_done), 64'(k == 7));
        end

        // mid-word LOAD, then mid-word reset
        step("mw_ld", 1, 2'd3, 0, 0, 8'h00, 0);
        for (int k = 0; k < 3; k++) step("mw_shl", 1, 2'd1, 1, 0, 8'h00, 0);
        step("mw_ldFF", 1, 2'd3, 0, 0, 8'hFF, 0);
        check("mw_cnt", 64'(cnt), 64'h0);
        check("mw_wd", 64'(word_done), 64'h0);
        for (int k = 0; k < 5; k++) step("mw_shl5", 1, 2'd1, 0, 0, 8'h00, 0);
        async_reset("mw_rst");

`ifdef USHIFT_ROTATE_EN
        step("rot_ld", 1, 2'd3, 0, 0, 8'h81, 0);
        step("rot_shl", 1, 2'd1, 0, 0, 8'h00, 1);
        check("rot_shl_out", 64'(out), 64'h03);
        step("rot_ld2", 1, 2'd3, 0, 0, 8'h81, 0);
        for (int k = 0; k < 8; k++) step("rot_shr", 1, 2'd2, 0, 0, 8'h00, 1);
        check("rot_shr_out", 64'(out), 64'h81);
        check("rot_shr_wd", 64'(word_done), 64'h1);
`endif

        // random traffic with occasional mid-word resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd", 1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
